// File: rtl/instr_encoder_loader_pkg.sv
// ISA constants shared by the instruction encoder/loader and the decoder:
// field widths, field LSB positions, opcode values and the loader FSM states.
package instr_encoder_loader_pkg;

  localparam int INSTRUCTION_WIDTH = 29;
  localparam int WIDTH_OPCODE      = 5;
  localparam int REGFILE_ADDR_BITS = 4;
  localparam int IMMEDIATE_WIDTH   = 12;
  localparam int IMEM_ADDR_BITS    = 8;
  localparam int BUC_IMM_WIDTH     = 24;
  localparam int WORD_COUNT_BITS   = IMEM_ADDR_BITS + 1;

  localparam int OPCODE_LSB = 24;
  localparam int RDST_LSB   = 20;
  localparam int RSRC_LSB   = 16;
  localparam int RTGT_LSB   = 12;

  typedef logic [WIDTH_OPCODE-1:0] opcode_t;

  localparam opcode_t OP_NOP   = 5'd0;
  localparam opcode_t OP_LR    = 5'd1;
  localparam opcode_t OP_SR    = 5'd2;
  localparam opcode_t OP_ADD   = 5'd3;
  localparam opcode_t OP_ADDI  = 5'd4;
  localparam opcode_t OP_SUB   = 5'd5;
  localparam opcode_t OP_MOV   = 5'd6;
  localparam opcode_t OP_INCR  = 5'd7;
  localparam opcode_t OP_LI    = 5'd8;
  localparam opcode_t OP_BEQ   = 5'd9;
  localparam opcode_t OP_BNEQ  = 5'd10;
  localparam opcode_t OP_BUC   = 5'd11;
  localparam opcode_t OP_AND   = 5'd12;
  localparam opcode_t OP_OR    = 5'd13;
  localparam opcode_t OP_NOT   = 5'd14;
  localparam opcode_t OP_XOR   = 5'd15;
  localparam opcode_t OP_SHIFL = 5'd16;
  localparam opcode_t OP_SHIFR = 5'd17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE,
    ST_ERROR
  } load_state_e;

  localparam logic signed [BUC_IMM_WIDTH-1:0] IMM_MIN = -24'sd2048;
  localparam logic signed [BUC_IMM_WIDTH-1:0] IMM_MAX = 24'sd4095;

  // True when a signed immediate is representable in the 12-bit field,
  // accepting both signed offsets and unsigned constants up to 4095.
  function automatic logic imm_fits_field(input logic [BUC_IMM_WIDTH-1:0] imm);
    logic signed [BUC_IMM_WIDTH-1:0] s_imm;
    s_imm = imm;
    return (s_imm >= IMM_MIN) && (s_imm <= IMM_MAX);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle stream plus instruction-memory write port of the loader.
// slave: the loader (consumes bundles, drives memory writes).
// master: the environment (produces bundles, acts as the memory).
interface instr_encoder_loader_if;
  import instr_encoder_loader_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic                          in_last;
  logic [WIDTH_OPCODE-1:0]       in_op;
  logic [REGFILE_ADDR_BITS-1:0]  in_rd;
  logic [REGFILE_ADDR_BITS-1:0]  in_rs;
  logic [REGFILE_ADDR_BITS-1:0]  in_rt;
  logic [BUC_IMM_WIDTH-1:0]      in_imm;
  logic                          mem_we;
  logic                          mem_ready;
  logic [IMEM_ADDR_BITS-1:0]     mem_addr;
  logic [INSTRUCTION_WIDTH-1:0]  mem_wdata;

  modport master (
    output in_valid, in_last, in_op, in_rd, in_rs, in_rt, in_imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_last, in_op, in_rd, in_rs, in_rt, in_imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/instr_encoder_loader_field_packer.sv
// Combinational packer: opcode + register/immediate fields -> canonical
// 29-bit instruction word, with unused fields forced to zero.
// Optional feature macro: IMM_RANGE_CHECK_EN (flags non-BUC immediates
// outside -2048..4095 instead of silently truncating them).
module instr_encoder_loader_field_packer
  import instr_encoder_loader_pkg::*;
(
  input  logic [WIDTH_OPCODE-1:0]      op,
  input  logic [REGFILE_ADDR_BITS-1:0] rd,
  input  logic [REGFILE_ADDR_BITS-1:0] rs,
  input  logic [REGFILE_ADDR_BITS-1:0] rt,
  input  logic [BUC_IMM_WIDTH-1:0]     imm,
  output logic [INSTRUCTION_WIDTH-1:0] word,
  output logic                         illegal_op,
  output logic                         imm_err
);

  logic [REGFILE_ADDR_BITS-1:0] f_rd;
  logic [REGFILE_ADDR_BITS-1:0] f_rs;
  logic [REGFILE_ADDR_BITS-1:0] f_rt;
  logic [IMMEDIATE_WIDTH-1:0]   f_imm;

  // Select which fields each opcode carries, then assemble the word.
  always_comb begin
    f_rd       = '0;
    f_rs       = '0;
    f_rt       = '0;
    f_imm      = '0;
    illegal_op = 1'b0;
    case (op)
      OP_NOP: ;
      OP_LR: begin
        f_rd  = rd;
        f_rs  = rs;
        f_imm = imm[IMMEDIATE_WIDTH-1:0];
      end
      OP_SR, OP_BEQ, OP_BNEQ: begin
        f_rs  = rs;
        f_rt  = rt;
        f_imm = imm[IMMEDIATE_WIDTH-1:0];
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        f_rd = rd;
        f_rs = rs;
        f_rt = rt;
      end
      OP_ADDI: begin
        f_rd  = rd;
        f_rs  = rd;
        f_imm = imm[IMMEDIATE_WIDTH-1:0];
      end
      OP_INCR: begin
        f_rd = rd;
        f_rs = rd;
      end
      OP_MOV, OP_NOT: begin
        f_rd = rd;
        f_rs = rs;
      end
      OP_LI: begin
        f_rd  = rd;
        f_imm = imm[IMMEDIATE_WIDTH-1:0];
      end
      OP_BUC: ;
      OP_SHIFL, OP_SHIFR: begin
        f_rd  = rd;
        f_rs  = rs;
        f_imm = imm[IMMEDIATE_WIDTH-1:0];
      end
      default: illegal_op = 1'b1;
    endcase

    if (illegal_op) begin
      word = '0;
    end else if (op == OP_BUC) begin
      word = {op, imm};
    end else begin
      word = {op, f_rd, f_rs, f_rt, f_imm};
    end
  end

  // Immediate range check for every opcode except BUC, whose 24 bits always fit.
  always_comb begin
`ifdef IMM_RANGE_CHECK_EN
    imm_err = (op != OP_BUC) && !imm_fits_field(imm);
`else
    imm_err = 1'b0;
`endif
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts field bundles, packs them into
// instruction words and writes them to consecutive instruction-memory
// addresses through a one-entry output register.
// Optional feature macro: IMM_RANGE_CHECK_EN (see field packer).
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [IMEM_ADDR_BITS-1:0]  base_addr,
  instr_encoder_loader_if.slave      bus,
  output logic                       done,
  output logic                       err,
  output logic [WORD_COUNT_BITS-1:0] word_count
);

  localparam logic [IMEM_ADDR_BITS:0]    ADDR_ONE  = 1;
  localparam logic [WORD_COUNT_BITS-1:0] COUNT_ONE = 1;

  load_state_e                  state_q, state_d;
  logic                         mem_we_q, mem_we_d;
  logic [IMEM_ADDR_BITS-1:0]    mem_addr_q, mem_addr_d;
  logic [INSTRUCTION_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  // One bit wider than the memory address so a write past the top is visible.
  logic [IMEM_ADDR_BITS:0]      next_addr_q, next_addr_d;
  logic                         err_q, err_d;
  logic [WORD_COUNT_BITS-1:0]   word_count_q, word_count_d;

  logic                         in_ready_int;
  logic                         accept;
  logic                         write_fire;
  logic                         start_ok;
  logic                         bundle_bad;
  logic [INSTRUCTION_WIDTH-1:0] packed_word;
  logic                         illegal_op;
  logic                         imm_err;

  instr_encoder_loader_field_packer u_packer (
    .op         (bus.in_op),
    .rd         (bus.in_rd),
    .rs         (bus.in_rs),
    .rt         (bus.in_rt),
    .imm        (bus.in_imm),
    .word       (packed_word),
    .illegal_op (illegal_op),
    .imm_err    (imm_err)
  );

  assign accept     = bus.in_valid && in_ready_int;
  assign write_fire = mem_we_q && bus.mem_ready;
  assign start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_ERROR));
  assign bundle_bad = illegal_op || imm_err || next_addr_q[IMEM_ADDR_BITS];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: load until the last bundle or an error, then drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (accept) begin
          if (bundle_bad)       state_d = ST_ERROR;
          else if (bus.in_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (!mem_we_q || bus.mem_ready) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: if (start) state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath registers; a reset drops any pending write immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      next_addr_q  <= '0;
      err_q        <= 1'b0;
      word_count_q <= '0;
    end else begin
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      next_addr_q  <= next_addr_d;
      err_q        <= err_d;
      word_count_q <= word_count_d;
    end
  end

  // Output register, address and count updates; the register holds while stalled.
  always_comb begin
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    next_addr_d  = next_addr_q;
    err_d        = err_q;
    word_count_d = word_count_q;

    if (write_fire) begin
      mem_we_d     = 1'b0;
      word_count_d = word_count_q + COUNT_ONE;
    end

    if (start_ok) begin
      next_addr_d  = {1'b0, base_addr};
      word_count_d = '0;
      err_d        = 1'b0;
    end

    if ((state_q == ST_LOAD) && accept) begin
      if (bundle_bad) begin
        err_d = 1'b1;
      end else begin
        mem_we_d    = 1'b1;
        mem_addr_d  = next_addr_q[IMEM_ADDR_BITS-1:0];
        mem_wdata_d = packed_word;
        next_addr_d = next_addr_q + ADDR_ONE;
      end
    end
  end

  // Handshake and status outputs.
  always_comb begin
    in_ready_int = (state_q == ST_LOAD) && (!mem_we_q || bus.mem_ready);
    done         = (state_q == ST_DONE);
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign err           = err_q;
  assign word_count    = word_count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed programs plus
// randomized programs checked against a behavioural loader model.
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic       done;
  logic       err;
  logic [8:0] word_count;

  instr_encoder_loader_if bus();

  instr_encoder_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .bus        (bus),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int rd;
    int rs;
    int rt;
    int imm;
    bit last;
  } bundle_t;

  typedef struct {
    int addr;
    int data;
  } write_t;

  int      checkCount = 0;
  int      errorCount = 0;
  bundle_t prog[$];
  write_t  expWrites[$];
  int      obsData[$];
  int      obsAddr[$];
  bit      expErr;
  int      expCount;
  int      expConsumed;

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one field bundle onto the stream.
  task automatic applyStimulus(input bundle_t b, input bit valid);
    bus.in_valid = valid;
    bus.in_op    = 5'(b.op);
    bus.in_rd    = 4'(b.rd);
    bus.in_rs    = 4'(b.rs);
    bus.in_rt    = 4'(b.rt);
    bus.in_imm   = 24'(b.imm);
    bus.in_last  = b.last;
  endtask

  function automatic bundle_t mk(input int op, input int rd, input int rs, input int rt, input int imm, input bit last);
    bundle_t b;
    b.op = op; b.rd = rd; b.rs = rs; b.rt = rt; b.imm = imm; b.last = last;
    return b;
  endfunction

  // Reference encoding from the ISA field table, using plain arithmetic.
  function automatic int modelEncode(input bundle_t b);
    int imm12 = b.imm & 'hFFF;
    int d = 0, s = 0, t = 0, i = 0;
    case (b.op)
      1:              begin d = b.rd; s = b.rs; i = imm12; end
      2, 9, 10:       begin s = b.rs; t = b.rt; i = imm12; end
      3, 5, 12, 13, 15: begin d = b.rd; s = b.rs; t = b.rt; end
      4:              begin d = b.rd; s = b.rd; i = imm12; end
      7:              begin d = b.rd; s = b.rd; end
      6, 14:          begin d = b.rd; s = b.rs; end
      8:              begin d = b.rd; i = imm12; end
      11:             return b.op * (1 << 24) + (b.imm & 'hFFFFFF);
      16, 17:         begin d = b.rd; s = b.rs; i = imm12; end
      default: ;
    endcase
    return b.op * (1 << 24) + d * (1 << 20) + s * (1 << 16) + t * (1 << 12) + i;
  endfunction

  function automatic bit rangeBad(input bundle_t b);
`ifdef IMM_RANGE_CHECK_EN
    return (b.op != 11) && (b.imm < -2048 || b.imm > 4095);
`else
    return 1'b0;
`endif
  endfunction

  // Expected write list, error outcome and number of bundles consumed.
  function automatic void buildExpected(input int base);
    int addr = base;
    expWrites.delete();
    expErr = 1'b0;
    expConsumed = 0;
    foreach (prog[i]) begin
      expConsumed++;
      if (prog[i].op > 17 || addr > 255 || rangeBad(prog[i])) begin
        expErr = 1'b1;
        break;
      end
      expWrites.push_back('{addr, modelEncode(prog[i])});
      addr++;
      if (prog[i].last) break;
    end
    expCount = expWrites.size();
  endfunction

  function automatic int obsDataAt(input int i);
    return (i < obsData.size()) ? obsData[i] : -1;
  endfunction

  function automatic int obsAddrAt(input int i);
    return (i < obsAddr.size()) ? obsAddr[i] : -1;
  endfunction

  // Start a load of prog[] at base and watch the stream/memory cycle by cycle.
  task automatic runProgram(input int base, input int validPct, input int readyPct,
                            input int stallAt, input int stallLen, input string name);
    int         idx = 0;
    int         cyc = 0;
    int         tail = -1;
    int         doneSeen = 0;
    bit         prevStall = 1'b0;
    bit         expectWe = 1'b0;
    logic [7:0] prevAddr = '0;
    logic [28:0] prevData = '0;
    write_t     w;
    buildExpected(base);
    obsData.delete();
    obsAddr.delete();
    @(negedge clk);
    start = 1'b1; base_addr = 8'(base); bus.in_valid = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (tail != 0 && cyc < 400) begin
      if (idx < prog.size()) applyStimulus(prog[idx], int'($urandom_range(99)) < validPct);
      else bus.in_valid = 1'b0;
      if (stallLen > 0 && cyc >= stallAt && cyc < stallAt + stallLen) bus.mem_ready = 1'b0;
      else bus.mem_ready = int'($urandom_range(99)) < readyPct;
      #1;
      if (cyc == 0) begin
        checkOutput({name, ":err_after_start"}, 32'(err), 32'd0);
        checkOutput({name, ":count_after_start"}, 32'(word_count), 32'd0);
      end
      if (prevStall) begin
        checkOutput({name, ":hold_we"}, 32'(bus.mem_we), 32'd1);
        checkOutput({name, ":hold_addr"}, 32'(bus.mem_addr), 32'(prevAddr));
        checkOutput({name, ":hold_data"}, 32'(bus.mem_wdata), 32'(prevData));
      end
      if (expectWe) checkOutput({name, ":latency_we"}, 32'(bus.mem_we), 32'd1);
      if (bus.mem_we && !bus.mem_ready) checkOutput({name, ":ready_blocked"}, 32'(bus.in_ready), 32'd0);
      if (tail < 0 && (done || err)) tail = 3;
      if (tail > 0) begin
        checkOutput({name, ":tail_ready"}, 32'(bus.in_ready), 32'd0);
        checkOutput({name, ":tail_we"}, 32'(bus.mem_we), 32'd0);
        tail--;
      end
      if (bus.mem_we && bus.mem_ready) begin
        obsAddr.push_back(int'(bus.mem_addr));
        obsData.push_back(int'(bus.mem_wdata));
        if (expWrites.size() == 0) begin
          checkOutput({name, ":extra_write"}, 32'd1, 32'd0);
        end else begin
          w = expWrites.pop_front();
          checkOutput({name, ":wr_addr"}, 32'(bus.mem_addr), 32'(w.addr));
          checkOutput({name, ":wr_data"}, 32'(bus.mem_wdata), 32'(w.data));
        end
      end
      prevStall = bus.mem_we && !bus.mem_ready;
      prevAddr  = bus.mem_addr;
      prevData  = bus.mem_wdata;
      expectWe  = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        expectWe = (idx < expConsumed) && !(expErr && idx == expConsumed - 1);
        idx++;
      end
      if (done) doneSeen++;
      cyc++;
      if (tail != 0) @(negedge clk);
    end
    if (tail != 0) checkOutput({name, ":timeout"}, 32'd1, 32'd0);
    bus.in_valid = 1'b0;
    checkOutput({name, ":missing_writes"}, 32'(expWrites.size()), 32'd0);
    checkOutput({name, ":err"}, 32'(err), 32'(expErr));
    checkOutput({name, ":word_count"}, 32'(word_count), 32'(expCount));
    checkOutput({name, ":done_pulses"}, 32'(doneSeen), expErr ? 32'd0 : 32'd1);
    checkOutput({name, ":consumed"}, 32'(idx), 32'(expConsumed));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len, base, opv, immv, vp, rp;
    logic signed [23:0] rimm;
    rst_n = 1'b0; start = 1'b0; base_addr = '0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_op = '0; bus.in_rd = '0;
    bus.in_rs = '0; bus.in_rt = '0; bus.in_imm = '0; bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    checkOutput("rst_word_count", 32'(word_count), 32'd0);
    rst_n = 1'b1;

    // lr R1,0x10(R0); add R3,R1,R2
    prog.delete();
    prog.push_back(mk(1, 1, 0, 0, 16, 0));
    prog.push_back(mk(3, 3, 1, 2, 0, 1));
    runProgram(0, 100, 100, -1, 0, "p1");
    checkOutput("p1_w0", 32'(obsDataAt(0)), 32'h1100010);
    checkOutput("p1_a0", 32'(obsAddrAt(0)), 32'h00);
    checkOutput("p1_w1", 32'(obsDataAt(1)), 32'h3312000);
    checkOutput("p1_a1", 32'(obsAddrAt(1)), 32'h01);
    checkOutput("p1_count", 32'(word_count), 32'd2);

    // bneq, buc with negative immediates, incr with rs forced to rd
    prog.delete();
    prog.push_back(mk(10, 0, 2, 3, -3, 0));
    prog.push_back(mk(11, 0, 0, 0, -2, 0));
    prog.push_back(mk(7, 2, 5, 0, 0, 1));
    runProgram(16, 80, 50, -1, 0, "p2");
    checkOutput("p2_bneq", 32'(obsDataAt(0)), 32'hA023FFD);
    checkOutput("p2_buc", 32'(obsDataAt(1)), 32'hBFFFFFE);
    checkOutput("p2_incr", 32'(obsDataAt(2)), 32'h7220000);

    // mem_ready held low three cycles mid-stream
    prog.delete();
    prog.push_back(mk(3, 1, 2, 3, 0, 0));
    prog.push_back(mk(5, 4, 5, 6, 0, 0));
    prog.push_back(mk(12, 7, 8, 9, 0, 0));
    prog.push_back(mk(13, 10, 11, 12, 0, 0));
    prog.push_back(mk(15, 13, 14, 15, 0, 0));
    prog.push_back(mk(6, 1, 9, 0, 0, 1));
    runProgram(32, 100, 100, 3, 3, "p3_stall");
    checkOutput("p3_count", 32'(word_count), 32'd6);

    // illegal opcode mid-program
    prog.delete();
    prog.push_back(mk(3, 1, 2, 3, 0, 0));
    prog.push_back(mk(20, 1, 1, 1, 0, 0));
    prog.push_back(mk(3, 2, 2, 2, 0, 1));
    runProgram(48, 100, 100, -1, 0, "p4_badop");
    checkOutput("p4_err", 32'(err), 32'd1);
    checkOutput("p4_writes", 32'(obsData.size()), 32'd1);

    // start from ERROR clears err and loads again
    prog.delete();
    prog.push_back(mk(1, 4, 5, 0, 100, 0));
    prog.push_back(mk(2, 0, 6, 7, -1, 1));
    runProgram(48, 100, 100, -1, 0, "p5_recover");
    checkOutput("p5_err", 32'(err), 32'd0);
    checkOutput("p5_count", 32'(word_count), 32'd2);

    // address wrap
    prog.delete();
    prog.push_back(mk(3, 1, 1, 1, 0, 0));
    prog.push_back(mk(3, 2, 2, 2, 0, 1));
    runProgram(255, 100, 100, -1, 0, "p6_wrap");
    checkOutput("p6_addr", 32'(obsAddrAt(0)), 32'hFF);
    checkOutput("p6_err", 32'(err), 32'd1);
    checkOutput("p6_writes", 32'(obsData.size()), 32'd1);

    // li with an out-of-field immediate
    prog.delete();
    prog.push_back(mk(8, 3, 0, 0, 5000, 1));
    runProgram(80, 100, 100, -1, 0, "p7_li");
`ifdef IMM_RANGE_CHECK_EN
    checkOutput("p7_err", 32'(err), 32'd1);
`else
    checkOutput("p7_word", 32'(obsDataAt(0)), 32'h8300388);
`endif

    // reset in the middle of LOAD with a write pending
    @(negedge clk);
    start = 1'b1; base_addr = 8'h40;
    @(negedge clk);
    start = 1'b0; bus.mem_ready = 1'b0;
    applyStimulus(mk(3, 1, 2, 3, 0, 0), 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checkOutput("midrst_pending", 32'(bus.mem_we), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midrst_we", 32'(bus.mem_we), 32'd0);
    checkOutput("midrst_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("midrst_count", 32'(word_count), 32'd0);
    checkOutput("midrst_addr", 32'(bus.mem_addr), 32'd0);
    rst_n = 1'b1; bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("midrst_dropped", 32'(bus.mem_we), 32'd0);

    // randomized programs
    for (int p = 0; p < 25; p++) begin
      prog.delete();
      len = int'($urandom_range(8, 1));
      for (int k = 0; k < len; k++) begin
        opv = ($urandom_range(99) < 6) ? int'($urandom_range(31, 18)) : int'($urandom_range(17, 0));
        if ($urandom_range(3) == 0) begin
          rimm = 24'($urandom);
          immv = rimm;
        end else begin
          immv = int'($urandom_range(8000)) - 3000;
        end
        prog.push_back(mk(opv, int'($urandom_range(15)), int'($urandom_range(15)),
                          int'($urandom_range(15)), immv, k == len - 1));
      end
      base = ($urandom_range(99) < 20) ? int'($urandom_range(255, 250)) : int'($urandom_range(255));
      vp = int'($urandom_range(100, 40));
      rp = int'($urandom_range(100, 40));
      runProgram(base, vp, rp, int'($urandom_range(6)), int'($urandom_range(3)), $sformatf("rnd%0d", p));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
